// File: rtl/dac_wave_scheduler.sv
// dac_wave_scheduler: paces the DDS core, runs continuous or fixed-length bursts,
// and applies gain/offset/clamp before handing codes to the parallel DAC driver.
module dac_wave_scheduler #(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 16
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  dds_sample,
    output logic        sample_en,
    output logic [7:0]  dac_code,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [DIV_W-1:0]   DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] LEN_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t state, state_n;

    logic [DIV_W-1:0]   div_reg, div_sh, div_cnt, div_n;
    logic [BURST_W-1:0] len_reg, len_sh, smp_cnt, smp_n;
    logic [7:0]         gain_reg, off_reg, idle_reg;
    logic               drain_cnt, drain_n;
    logic               sen_n, flush, launch;

    logic               en_d1, cap_v;
    logic [7:0]         cap;

    logic signed [8:0]  s;
    logic signed [17:0] p, q, r;
    logic [7:0]         code_n;

    assign launch = (state == IDLE) && start && !stop;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= '0;
            len_reg  <= '0;
            gain_reg <= 8'd128;
            off_reg  <= 8'd128;
            idle_reg <= 8'h80;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    div_reg  <= cfg_wdata[DIV_W-1:0];
                3'd1:    len_reg  <= cfg_wdata[BURST_W-1:0];
                3'd2:    gain_reg <= cfg_wdata[7:0];
                3'd3:    off_reg  <= cfg_wdata[7:0];
                3'd4:    idle_reg <= cfg_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Run geometry is frozen at start so host writes cannot disturb a burst.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_sh <= '0;
            len_sh <= '0;
        end else if (launch) begin
            div_sh <= div_reg;
            len_sh <= len_reg;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        smp_n   = smp_cnt;
        drain_n = drain_cnt;
        flush   = 1'b0;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_n = RUN;
                    div_n   = '0;
                    smp_n   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else begin
                    div_n = (div_cnt == div_sh) ? '0 : div_cnt + DIV_ONE;
                    if (div_cnt == '0) begin
                        smp_n = smp_cnt + LEN_ONE;
                        if (len_sh != '0 && smp_cnt == len_sh - LEN_ONE) begin
                            state_n = DRAIN;
                            drain_n = 1'b0;
                        end
                    end
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else if (drain_cnt) begin
                    state_n = DONE;
                end else begin
                    drain_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        sen_n = (state_n == RUN) && (div_n == '0);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            smp_cnt   <= '0;
            drain_cnt <= 1'b0;
            sample_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            smp_cnt   <= smp_n;
            drain_cnt <= drain_n;
            sample_en <= sen_n;
            busy      <= (state_n == RUN) || (state_n == DRAIN);
            done      <= (state_n == DONE);
        end
    end

    // Two-stage sample path: capture one cycle after the strobe, then scale.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d1 <= 1'b0;
            cap_v <= 1'b0;
            cap   <= 8'h00;
        end else begin
            en_d1 <= flush ? 1'b0 : sample_en;
            cap_v <= flush ? 1'b0 : en_d1;
            if (en_d1) begin
                cap <= dds_sample;
            end
        end
    end

    always_comb begin
        s = $signed({1'b0, cap}) - 9'sd128;
        p = s * $signed({1'b0, gain_reg});
        q = p >>> 7;
        r = q + $signed({10'b0, off_reg});
        if (r[17]) begin
            code_n = 8'h00;
        end else if (r > 18'sd255) begin
            code_n = 8'hFF;
        end else begin
            code_n = r[7:0];
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_code <= 8'h80;
        end else if (state == IDLE || state == DONE || flush) begin
            dac_code <= idle_reg;
        end else if (cap_v) begin
            dac_code <= code_n;
        end
    end

endmodule
